// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for multi_cycle_mem_responder
package mem_pkg;

   localparam int WORD_W = 32;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

endpackage

// File: rtl/multi_cycle_mem_responder_if.sv
// rtl/multi_cycle_mem_responder_if.sv - CPU-side memory strobe/data bundle
interface multi_cycle_mem_responder_if;
   import mem_pkg::*;

   logic              MemRead;
   logic              MemWrite;
   logic [WORD_W-1:0] Address;
   logic [WORD_W-1:0] WriteData;
   logic [WORD_W-1:0] ReadData;
   logic              mem_ready;
   logic              mem_busy;
   logic              mem_err;

   modport master (
      output MemRead, MemWrite, Address, WriteData,
      input  ReadData, mem_ready, mem_busy, mem_err
   );

   modport slave (
      input  MemRead, MemWrite, Address, WriteData,
      output ReadData, mem_ready, mem_busy, mem_err
   );

endinterface

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port word RAM with registered, enable-held read data
module mem_array
   import mem_pkg::*;
#(
   parameter int    ADDR_W    = 10,
   parameter string INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] idx,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] r_mem [0:(1<<ADDR_W)-1];

   // Word write; only strobed on the edge that completes a store
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[idx] <= wdata;
      end
   end

   // Read data register holds its value until the next completed read
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= r_mem[idx];
      end
   end

endmodule

// File: rtl/multi_cycle_mem_responder.sv
// rtl/multi_cycle_mem_responder.sv - wait-state memory responder (optional MEM_ALIGN_CHECK_EN)
module multi_cycle_mem_responder
   import mem_pkg::*;
#(
   parameter int    ADDR_W    = 10,
   parameter int    LATENCY   = 2,
   parameter string INIT_FILE = ""
) (
   input  logic                          clk,
   input  logic                          reset,
   multi_cycle_mem_responder_if.slave    bus
);

   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

   state_t              r_state;
   op_t                 r_op;
   logic [CNT_W-1:0]    r_cnt;
   logic [ADDR_W-1:0]   r_idx;
   logic [WORD_W-1:0]   r_wdata;
   logic                r_ready;
   logic                r_busy;

   logic                w_req;
   op_t                 w_op;
   logic [ADDR_W-1:0]   w_in_idx;
   logic                w_misalign;
   logic [CNT_W-1:0]    w_cnt_dec;
   logic                w_idle_to_resp;
   logic                w_busy_to_resp;
   logic                w_enter_resp;
   logic                w_enter_err;
   op_t                 w_acc_op;
   logic [ADDR_W-1:0]   w_acc_idx;
   logic [WORD_W-1:0]   w_acc_wdata;
   logic                w_we;
   logic                w_re;
   logic [WORD_W-1:0]   w_rdata;
   logic                w_unused;

   assign w_req    = bus.MemRead | bus.MemWrite;
   assign w_op     = bus.MemWrite ? OP_WR : OP_RD;
   assign w_in_idx = bus.Address[ADDR_W+1:2];
   assign w_unused = ^{bus.Address[WORD_W-1:ADDR_W+2], bus.Address[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
   logic r_err;
   assign w_misalign  = |bus.Address[1:0];
   assign bus.mem_err = r_err;
`else
   assign w_misalign  = 1'b0;
   assign bus.mem_err = 1'b0;
`endif

   assign w_cnt_dec      = r_cnt - 1'b1;
   assign w_idle_to_resp = (r_state == IDLE) && w_req && (w_misalign || (LAT_M1 == '0));
   assign w_busy_to_resp = (r_state == BUSY) && (w_cnt_dec == '0);
   assign w_enter_resp   = w_idle_to_resp || w_busy_to_resp;
   assign w_enter_err    = w_idle_to_resp && w_misalign;

   // A zero-wait access completes on its accept edge, so it uses the live request
   assign w_acc_op    = (r_state == IDLE) ? w_op           : r_op;
   assign w_acc_idx   = (r_state == IDLE) ? w_in_idx       : r_idx;
   assign w_acc_wdata = (r_state == IDLE) ? bus.WriteData  : r_wdata;

   // Array strobes fire only on the edge entering RESP; reset blocks any commit
   assign w_we = reset && w_enter_resp && !w_enter_err && (w_acc_op == OP_WR);
   assign w_re = reset && w_enter_resp && !w_enter_err && (w_acc_op == OP_RD);

   mem_array #(
      .ADDR_W    (ADDR_W),
      .INIT_FILE (INIT_FILE)
   ) u_mem_array (
      .clk   (clk),
      .reset (reset),
      .we    (w_we),
      .re    (w_re),
      .idx   (w_acc_idx),
      .wdata (w_acc_wdata),
      .rdata (w_rdata)
   );

   assign bus.ReadData  = w_rdata;
   assign bus.mem_ready = r_ready;
   assign bus.mem_busy  = r_busy;

   // Request FSM: latch on accept, count wait states, pulse ready for one cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_op    <= OP_RD;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_wdata <= '0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_op    <= w_op;
                  r_idx   <= w_in_idx;
                  r_wdata <= bus.WriteData;
                  r_cnt   <= LAT_M1;
                  if (w_idle_to_resp) begin
                     r_state <= RESP;
                     r_ready <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= BUSY;
                     r_busy  <= 1'b1;
                  end
               end
            end
            BUSY: begin
               r_cnt <= w_cnt_dec;
               if (w_busy_to_resp) begin
                  r_state <= RESP;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   // Error flag is raised only for the RESP cycle of a misaligned accept
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_enter_err;
      end
   end
`endif

endmodule

// File: tb/tb_multi_cycle_mem_responder.sv
// tb/tb_multi_cycle_mem_responder.sv - directed self-checking bench for multi_cycle_mem_responder
module tb_multi_cycle_mem_responder;

   localparam int LATENCY = 2;
   localparam int ADDR_W  = 10;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   multi_cycle_mem_responder_if bus ();

   multi_cycle_mem_responder #(
      .ADDR_W    (ADDR_W),
      .LATENCY   (LATENCY),
      .INIT_FILE ("")
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drives one access, measures accept-to-ready cycles and checks the ready pulse
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data,
                         input int exp_lat, input logic exp_err);
      int cyc;
      bit seen;
      @(negedge clk);
      bus.MemRead   = rd;
      bus.MemWrite  = wr;
      bus.Address   = addr;
      bus.WriteData = data;
      cyc  = 0;
      seen = 0;
      while (!seen && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.mem_ready) begin
            seen = 1;
            check({tag, "_err"}, 32'(bus.mem_err), 32'(exp_err));
            check({tag, "_busy_at_ready"}, 32'(bus.mem_busy), 32'd0);
         end else if (cyc == 1) begin
            check({tag, "_busy"}, 32'(bus.mem_busy), 32'd1);
         end
      end
      check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
      @(negedge clk);
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_ready_pulse"}, 32'(bus.mem_ready), 32'd0);
   endtask

   initial begin
      int cyc;
      bit ready_seen;
      n_checks = 0;
      n_fail   = 0;
      bus.MemRead   = 1'b1;
      bus.MemWrite  = 1'b0;
      bus.Address   = 32'h0;
      bus.WriteData = 32'h0;
      reset = 1'b0;

      // Reset held 5 cycles with MemRead high
      ready_seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (bus.mem_ready) ready_seen = 1;
      end
      check("rst_no_ready", 32'(ready_seen), 32'd0);
      check("rst_readdata", bus.ReadData, 32'h0);
      check("rst_busy", 32'(bus.mem_busy), 32'd0);
      check("rst_err", 32'(bus.mem_err), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      cyc = 0;
      while (!bus.mem_ready && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("rst_release_latency", 32'(cyc), 32'(LATENCY));
      @(negedge clk);
      bus.MemRead = 1'b0;
      @(posedge clk);
      #1;

      // Write then read back
      access("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, LATENCY, 1'b0);
      access("rd10", 1'b1, 1'b0, 32'h10, 32'h0, LATENCY, 1'b0);
      check("rd10_data", bus.ReadData, 32'hDEADBEEF);

      // Read and write together: write wins, ReadData untouched
      access("rw20", 1'b1, 1'b1, 32'h20, 32'h1234, LATENCY, 1'b0);
      check("rw20_data_held", bus.ReadData, 32'hDEADBEEF);
      access("rd20", 1'b1, 1'b0, 32'h20, 32'h0, LATENCY, 1'b0);
      check("rd20_data", bus.ReadData, 32'h1234);

      // Address wrap modulo 4*2**ADDR_W bytes
      access("wr1004", 1'b0, 1'b1, 32'h0000_1004, 32'hA5, LATENCY, 1'b0);
      access("rd0004", 1'b1, 1'b0, 32'h0000_0004, 32'h0, LATENCY, 1'b0);
      check("wrap_data", bus.ReadData, 32'hA5);

      // Reset during a write's BUSY phase discards the write
      access("wr30", 1'b0, 1'b1, 32'h30, 32'h1111_1111, LATENCY, 1'b0);
      @(negedge clk);
      bus.MemWrite  = 1'b1;
      bus.Address   = 32'h30;
      bus.WriteData = 32'h2222_2222;
      @(posedge clk);
      #1;
      check("abort_busy", 32'(bus.mem_busy), 32'd1);
      #1;
      reset = 1'b0;
      #1;
      check("abort_busy_cleared", 32'(bus.mem_busy), 32'd0);
      check("abort_readdata_rst", bus.ReadData, 32'h0);
      @(posedge clk);
      @(negedge clk);
      bus.MemWrite = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      access("rd30", 1'b1, 1'b0, 32'h30, 32'h0, LATENCY, 1'b0);
      check("abort_orig_word", bus.ReadData, 32'h1111_1111);

      // Misaligned read
`ifdef MEM_ALIGN_CHECK_EN
      access("rd13", 1'b1, 1'b0, 32'h13, 32'h0, 1, 1'b1);
      check("rd13_data_held", bus.ReadData, 32'h1111_1111);
`else
      access("rd13", 1'b1, 1'b0, 32'h13, 32'h0, LATENCY, 1'b0);
      check("rd13_data", bus.ReadData, 32'hDEADBEEF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
